// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and defaults.
//  XLEN, RESET_VECTOR, NOP_INSTR : default datapath width, boot PC, bubble encoding
//  fetch_state_e                 : fetch FSM states
//  if_id_t                       : IF/ID pipeline register payload
package cpu_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// Pipeline register holding one if_id_t with flush and write enable.
//  clk, rst  : clock, synchronous active-high reset
//  write_en  : capture d
//  flush     : replace content with a bubble tagged with flush_pc (beats write_en)
//  flush_pc  : PC kept in the bubble for debug visibility
//  d, q      : payload in / registered payload out
module if_id_register
  import cpu_pkg::*;
#(
  parameter logic [31:0] BUBBLE = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_en,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  if_id_t          d,
  output if_id_t          q
);

  // Priority: reset > flush > write > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q.pc    <= '0;
      q.instr <= BUBBLE;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.pc    <= flush_pc;
      q.instr <= BUBBLE;
      q.valid <= 1'b0;
    end else if (write_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, instruction-memory address, IF/ID register,
// BOOT/RUN/HALTED tracking, misaligned-redirect fault and fetch counter.
//  clk_i, rst_i          : clock, synchronous active-high reset
//  pc_write_en_i         : PC may advance/redirect this cycle
//  if_id_write_en_i      : IF/ID may capture this cycle
//  if_id_flush_i         : replace IF/ID with a bubble
//  halt_detected_i       : halt instruction seen in ID
//  redirect_req_i/target : EX-resolved taken branch/jump and its byte address
//  resume_i              : leave HALTED
//  imem_addr_o/rdata_i   : combinational instruction memory read at pc_q
//  if_id_*_o             : IF/ID contents, pc_plus4 derived from the stored PC
//  halted_o              : FSM in HALTED
//  fetch_fault_o         : one-cycle pulse after a misaligned redirect is taken
//  fetch_count_o         : number of valid instructions captured into IF/ID
module fetch_unit #(
  parameter int unsigned          XLEN         = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(cpu_pkg::RESET_VECTOR),
  parameter logic [31:0]          NOP_INSTR    = cpu_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_write_en_i,
  input  logic            if_id_write_en_i,
  input  logic            if_id_flush_i,
  input  logic            halt_detected_i,
  input  logic            redirect_req_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc_plus4_o,
  output logic [31:0]     if_id_instr_o,
  output logic            if_id_valid_o,
  output logic            halted_o,
  output logic            fetch_fault_o,
  output logic [31:0]     fetch_count_o
);

  import cpu_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [31:0]     count_q, count_d;
  logic            fetch_active;
  logic            force_flush;
  logic            capture_valid;
  if_id_t          if_id_d, if_id_q;

  // State, PC, fault and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Next state, next PC and fetch qualification.
  // The cycle a halt is accepted counts as a dead fetch: the PC holds and the
  // captured slot is invalid, so resume restarts at exactly that PC.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = 1'b0;
    fetch_active = 1'b0;
    force_flush  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_detected_i && !redirect_req_i) begin
          state_d = HALTED;
        end else begin
          fetch_active = 1'b1;
          if (pc_write_en_i) begin
            if (redirect_req_i) begin
              pc_d    = {redirect_target_i[XLEN-1:2], 2'b00};
              fault_d = |redirect_target_i[1:0];
            end else begin
              pc_d = pc_q + XLEN'(4);
            end
          end
        end
      end
      HALTED: begin
        force_flush = 1'b1;
        if (resume_i) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // IF/ID write payload; outside active fetch a write stores a bubble.
  always_comb begin
    if_id_d.pc    = pc_q;
    if_id_d.instr = fetch_active ? imem_rdata_i : NOP_INSTR;
    if_id_d.valid = fetch_active;
  end

  assign capture_valid = fetch_active && if_id_write_en_i && !if_id_flush_i;
  assign count_d       = count_q + 32'(capture_valid);

  if_id_register #(
    .BUBBLE(NOP_INSTR)
  ) u_if_id (
    .clk     (clk_i),
    .rst     (rst_i),
    .write_en(if_id_write_en_i),
    .flush   (if_id_flush_i || force_flush),
    .flush_pc(pc_q),
    .d       (if_id_d),
    .q       (if_id_q)
  );

  assign imem_addr_o      = pc_q;
  assign if_id_pc_o       = if_id_q.pc;
  assign if_id_pc_plus4_o = if_id_q.pc + XLEN'(4);
  assign if_id_instr_o    = if_id_q.instr;
  assign if_id_valid_o    = if_id_q.valid;
  assign halted_o         = (state_q == HALTED);
  assign fetch_fault_o    = fault_q;
  assign fetch_count_o    = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// halt/resume sequence and randomized traffic against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pc_we, ifid_we, flush, halt, redir, resume;
  logic [31:0] target;
  logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;
  logic        if_id_valid, halted, fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Address-indexed instruction memory image.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pc_write_en_i    (pc_we),
    .if_id_write_en_i (ifid_we),
    .if_id_flush_i    (flush),
    .halt_detected_i  (halt),
    .redirect_req_i   (redir),
    .redirect_target_i(target),
    .resume_i         (resume),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .if_id_pc_o       (if_id_pc),
    .if_id_pc_plus4_o (if_id_pc_plus4),
    .if_id_instr_o    (if_id_instr),
    .if_id_valid_o    (if_id_valid),
    .halted_o         (halted),
    .fetch_fault_o    (fault),
    .fetch_count_o    (fetch_count)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 = booting, 1 = running, 2 = halted
  int          m_mode  = 0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_ifpc  = 32'h0;
  logic [31:0] m_instr = NOP;
  logic        m_valid = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_count = 32'h0;

  task automatic model_edge();
    logic        active;
    logic [31:0] npc;
    int          nmode;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP;
      m_valid = 1'b0; m_fault = 1'b0; m_count = 32'h0;
    end else begin
      active = (m_mode == 1) && !(halt && !redir);
      if (flush || m_mode == 2) begin
        m_ifpc = m_pc; m_instr = NOP; m_valid = 1'b0;
      end else if (ifid_we) begin
        m_ifpc  = m_pc;
        m_valid = active;
        m_instr = active ? mem_word(m_pc) : NOP;
        if (active) m_count = m_count + 1;
      end
      m_fault = 1'b0;
      npc = m_pc;
      if (active && pc_we) begin
        if (redir) begin
          npc     = target & ~32'h3;
          m_fault = (target % 4) != 0;
        end else begin
          npc = m_pc + 4;
        end
      end
      nmode = m_mode;
      if (m_mode == 0) nmode = 1;
      else if (m_mode == 1 && halt && !redir) nmode = 2;
      else if (m_mode == 2 && resume) nmode = 1;
      m_pc   = npc;
      m_mode = nmode;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_imem_addr", imem_addr, m_pc);
    check("m_if_id_pc", if_id_pc, m_ifpc);
    check("m_if_id_pc_plus4", if_id_pc_plus4, m_ifpc + 32'd4);
    check("m_if_id_instr", if_id_instr, m_instr);
    check("m_if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check("m_halted", 32'(halted), 32'(m_mode == 2));
    check("m_fault", 32'(fault), 32'(m_fault));
    check("m_count", fetch_count, m_count);
  endtask

  task automatic drive(input logic r, input logic pw, input logic iw, input logic fl,
                       input logic h, input logic rd, input logic rs, input logic [31:0] t);
    rst = r; pc_we = pw; ifid_we = iw; flush = fl; halt = h; redir = rd; resume = rs; target = t;
  endtask

  // One clock: model advances on the same inputs, outputs sampled 1ns after the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, pc_we, ifid_we, flush, halt, redir, resume;
    logic [31:0] target;
    logic [31:0] e_pc, e_ifpc;
    logic        e_valid, e_halted, e_fault;
    logic [31:0] e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic pw, input logic iw, input logic fl, input logic h,
                     input logic rd, input logic rs, input logic [31:0] t,
                     input logic [31:0] pc, input logic [31:0] ifpc, input logic v,
                     input logic hl, input logic f, input logic [31:0] c);
    vec_t x;
    x.rst = r; x.pc_we = pw; x.ifid_we = iw; x.flush = fl; x.halt = h; x.redir = rd;
    x.resume = rs; x.target = t; x.e_pc = pc; x.e_ifpc = ifpc; x.e_valid = v;
    x.e_halted = hl; x.e_fault = f; x.e_count = c;
    vecs.push_back(x);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0);

    //   rst pw iw fl h rd rs target          pc            ifpc          v h f count
    add(1, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0, 0);   // reset
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0, 0);   // boot cycle, PC held
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h4,        32'h0,        1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h8,        32'h4,        1, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'hC,        32'h8,        1, 0, 0, 3);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h10,       32'hC,        1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h10,       32'hC,        1, 0, 0, 4);   // load-use stall
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h10,       32'hC,        1, 0, 0, 4);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h14,       32'h10,       1, 0, 0, 5);
    add(0, 1, 1, 1, 0, 1, 0, 32'h100,       32'h100,      32'h14,       0, 0, 0, 5);   // redirect + flush
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h104,      32'h100,      1, 0, 0, 6);
    add(0, 1, 1, 0, 0, 1, 0, 32'h102,       32'h100,      32'h104,      1, 0, 1, 7);   // misaligned
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h104,      32'h100,      1, 0, 0, 8);   // fault gone
    add(0, 1, 1, 1, 0, 1, 0, 32'h20,        32'h20,       32'h104,      0, 0, 0, 8);
    add(0, 1, 1, 0, 1, 0, 0, 32'h0,         32'h20,       32'h20,       0, 1, 0, 8);   // halt at 0x20
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h20,       32'h20,       0, 1, 0, 8);
    add(0, 1, 1, 0, 1, 0, 0, 32'h0,         32'h20,       32'h20,       0, 1, 0, 8);   // halt ignored
    add(0, 1, 1, 0, 0, 1, 0, 32'h80,        32'h20,       32'h20,       0, 1, 0, 8);   // redirect ignored
    add(0, 1, 1, 0, 0, 0, 1, 32'h0,         32'h20,       32'h20,       0, 0, 0, 8);   // resume
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h24,       32'h20,       1, 0, 0, 9);   // 0x20 fetched
    add(0, 1, 1, 0, 1, 1, 0, 32'h40,        32'h40,       32'h24,       1, 0, 0, 10);  // redirect beats halt
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h44,       32'h40,       1, 0, 0, 11);
    add(0, 1, 1, 0, 0, 0, 1, 32'h0,         32'h48,       32'h44,       1, 0, 0, 12);  // stray resume
    add(0, 1, 1, 0, 1, 0, 0, 32'h0,         32'h48,       32'h48,       0, 1, 0, 12);  // halt
    add(1, 1, 1, 0, 0, 0, 1, 32'h0,         32'h0,        32'h0,        0, 0, 0, 0);   // reset mid-halt
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 32'h103,       32'h0,        32'h0,        0, 0, 0, 0);   // reset beats redirect
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h4,        32'h0,        1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4,       1, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0,        32'hFFFF_FFFC, 1, 0, 0, 3);  // PC wraps
    add(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h4,        32'h0,        1, 0, 0, 4);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pc_we, vecs[i].ifid_we, vecs[i].flush, vecs[i].halt,
            vecs[i].redir, vecs[i].resume, vecs[i].target);
      tick();
      check($sformatf("v%0d_pc", i), imem_addr, vecs[i].e_pc);
      check($sformatf("v%0d_ifpc", i), if_id_pc, vecs[i].e_ifpc);
      check($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halted));
      check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].e_fault));
      check($sformatf("v%0d_count", i), fetch_count, vecs[i].e_count);
    end

    // Hand sequence: halt at 0x20, hold ten cycles under random controls, resume.
    drive(0, 1, 1, 1, 0, 1, 0, 32'h20);
    tick();
    drive(0, 1, 1, 0, 1, 0, 0, 32'h0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, $urandom);
      tick();
      check("halt_hold_pc", imem_addr, 32'h20);
      check("halt_hold_valid", 32'(if_id_valid), 32'h0);
      check("halt_hold_halted", 32'(halted), 32'h1);
    end
    drive(0, 1, 1, 0, 0, 0, 1, 32'h0);
    tick();
    check("resume_halted", 32'(halted), 32'h0);
    drive(0, 1, 1, 0, 0, 0, 0, 32'h0);
    tick();
    check("resume_ifpc", if_id_pc, 32'h20);
    check("resume_instr", if_id_instr, mem_word(32'h20));
    check("resume_valid", 32'(if_id_valid), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      case ($urandom_range(0, 3))
        0: t = $urandom;
        1: t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: t = $urandom & 32'h0000_0FFC;
      endcase
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, t);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
